// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory arbiter.
// Holds the access FSM state type and arbitration mode selectors.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_rr_arbiter.sv
// Combinational requester picker: fixed priority or round-robin.
// The round-robin pointer is owned by the caller.
module cpu_rr_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int PRIO_MODE = PRIO_FIXED,
    parameter int IW        = idx_w(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [IW-1:0]  idx
);

    logic found;
    int   c;

    // Search order starts just after the last winner in round-robin mode.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < NCH; i++) begin
            if (PRIO_MODE == PRIO_RR) begin
                c = (int'(ptr) + 1 + i) % NCH;
            end else begin
                c = i;
            end
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = c[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/cpu_memarb.sv
// Registered multi-requester arbiter onto a single external memory bus.
// Honours slave wait states and aborts stalled accesses after MAX_WAIT.
module cpu_memarb
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NCH       = 2,
    parameter int PRIO_MODE = PRIO_FIXED,
    parameter int MAX_WAIT  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        req_i,
    input  logic [NCH-1:0]        we_i,
    input  logic [NCH*ADDR_W-1:0] addr_i,
    input  logic [NCH*DATA_W-1:0] wdata_i,
    output logic [NCH-1:0]        gnt_o,
    output logic [NCH-1:0]        done_o,
    output logic [NCH-1:0]        err_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic                  re_o,
    output logic                  we_o,
    inout  wire  [DATA_W-1:0]     data_io,
    input  logic                  needWait_i
);

    localparam int IW = idx_w(NCH);
    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WSAT = '1;
    localparam logic [IW-1:0] PTR0 = IW'(NCH - 1);

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     win_idx;
    logic [NCH-1:0]    win_gnt;
    logic [DATA_W-1:0] wdata_q;
    logic [WW-1:0]     wcnt;
    logic              timeout;

    cpu_rr_arbiter #(
        .NCH       (NCH),
        .PRIO_MODE (PRIO_MODE),
        .IW        (IW)
    ) u_arb (
        .req   (req_i),
        .ptr   (ptr),
        .grant (win_gnt),
        .idx   (win_idx)
    );

    assign data_io = we_o ? wdata_q : {DATA_W{1'bz}};

    assign timeout = (MAX_WAIT != 0) && (wcnt == WMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= PTR0;
            gnt_o   <= '0;
            done_o  <= '0;
            err_o   <= '0;
            rdata_o <= '0;
            addr_o  <= '0;
            re_o    <= 1'b0;
            we_o    <= 1'b0;
            wdata_q <= '0;
            wcnt    <= '0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            unique case (state)
                IDLE: begin
                    if (|req_i) begin
                        gnt_o   <= win_gnt;
                        ptr     <= win_idx;
                        addr_o  <= addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
                        wdata_q <= wdata_i[int'(win_idx)*DATA_W +: DATA_W];
                        we_o    <= we_i[win_idx];
                        re_o    <= ~we_i[win_idx];
                        wcnt    <= '0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A slave releasing the stall wins over a due timeout.
                    if (!needWait_i) begin
                        if (re_o) begin
                            rdata_o <= data_io;
                        end
                        re_o   <= 1'b0;
                        we_o   <= 1'b0;
                        done_o <= gnt_o;
                        state  <= DONE;
                    end else if (timeout) begin
                        re_o   <= 1'b0;
                        we_o   <= 1'b0;
                        done_o <= gnt_o;
                        err_o  <= gnt_o;
                        state  <= DONE;
                    end else if (wcnt != WSAT) begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE: begin
                    gnt_o <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
